// File: rtl/mdu_pkg.sv
// MDU operation encodings and small decode helpers shared by the decoder and mdu_unit.
// MDU_MADD_EN enables the madd/maddu accumulate opcodes.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NULL  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Opcodes that launch a multi-cycle operation when qualified by Start.
  function automatic logic is_start_op(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    ok = 1'b1;
`endif
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_mult_class(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_MADD) || (op == MDU_MADDU);
  endfunction

  function automatic logic is_accumulate(input logic [3:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Decoder/E-stage <-> MDU signal bundle; the decode side drives the master modport.
interface mdu_unit_if;
  logic        Start;
  logic [3:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] MDUout;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDUop, A, B, Req,
    input  Busy, MDUout, HI, LO
  );

  modport slave (
    input  Start, MDUop, A, B, Req,
    output Busy, MDUout, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu and the madd/maddu product.
// wr is low when the operation must leave HI/LO untouched (division by zero).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output hilo_t       res,
  output logic        wr
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic               b_zero;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  assign a_mag  = a[31] ? (~a + 32'd1) : a;
  assign b_mag  = b[31] ? (~b + 32'd1) : b;
  assign b_zero = (b == 32'd0);
  assign q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign q_u    = b_zero ? 32'd0 : (a / b);
  assign r_u    = b_zero ? 32'd0 : (a % b);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    res = '0;
    wr  = 1'b0;
    case (op)
      MDU_MULT, MDU_MADD: begin
        res = hilo_t'(prod_s);
        wr  = 1'b1;
      end
      MDU_MULTU, MDU_MADDU: begin
        res = hilo_t'(prod_u);
        wr  = 1'b1;
      end
      MDU_DIV: begin
        res.lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        res.hi = a[31] ? (~r_mag + 32'd1) : r_mag;
        wr     = !b_zero;
      end
      MDU_DIVU: begin
        res.lo = q_u;
        res.hi = r_u;
        wr     = !b_zero;
      end
      default: begin
        res = '0;
        wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models latency with a Busy counter.
// Define MDU_MADD_EN to accept madd/maddu (accumulate into HI/LO at commit).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
)(
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state;
  state_e      state_next;
  logic [3:0]  cnt;
  hilo_t       hilo;
  hilo_t       pend;
  logic        pend_wr;
  logic        pend_acc;
  hilo_t       arith_res;
  logic        arith_wr;
  logic        accept;
  logic        commit;
  logic        idle_ok;

  mdu_arith u_arith (
    .op  (bus.MDUop),
    .a   (bus.A),
    .b   (bus.B),
    .res (arith_res),
    .wr  (arith_wr)
  );

  // Side effects in E only when no exception is being taken and no op is in flight.
  assign idle_ok = (state == S_IDLE) && !bus.Req;

  // NOTE: non-blocking assignments in clocked blocks so each register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (idle_ok && bus.Start && is_start_op(bus.MDUop)) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= is_mult_class(bus.MDUop) ? MULT_LOAD : DIV_LOAD;
    end else if ((state == S_RUN) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // NOTE: the pending result is reset too, so a reset mid-operation leaves nothing to commit later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_wr  <= 1'b0;
      pend_acc <= 1'b0;
    end else if (accept) begin
      pend     <= arith_res;
      pend_wr  <= arith_wr;
      pend_acc <= is_accumulate(bus.MDUop);
    end
  end

  // Accumulate reads HI/LO at commit, so an mthi/mtlo before launch is folded in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hilo <= '0;
    end else if (commit) begin
      if (pend_wr) begin
        if (pend_acc) hilo <= hilo_t'({hilo.hi, hilo.lo} + {pend.hi, pend.lo});
        else          hilo <= pend;
      end
    end else if (idle_ok) begin
      if (bus.MDUop == MDU_MTHI) hilo.hi <= bus.A;
      if (bus.MDUop == MDU_MTLO) hilo.lo <= bus.A;
    end
  end

  assign bus.Busy = (state == S_RUN);
  assign bus.HI   = hilo.hi;
  assign bus.LO   = hilo.lo;

  always_comb begin
    bus.MDUout = 32'd0;
    if (bus.MDUop == MDU_MFHI)      bus.MDUout = hilo.hi;
    else if (bus.MDUop == MDU_MFLO) bus.MDUout = hilo.lo;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural HI/LO model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: architectural HI/LO plus cycles left on the in-flight op.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_left = 0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_starts(input logic [3:0] op);
    bit ok;
    ok = (op >= 4'd1 && op <= 4'd4);
`ifdef MDU_MADD_EN
    if (op == 4'd9 || op == 4'd10) ok = 1'b1;
`endif
    return ok;
  endfunction

  function automatic int op_latency(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
  endfunction

  task automatic model_commit();
    logic [63:0] p;
    int          sa;
    int          sb;
    case (m_op)
      MDU_MULT:  begin p = longint'(signed'(m_a)) * longint'(signed'(m_b)); {m_hi, m_lo} = p; end
      MDU_MULTU: begin p = {32'd0, m_a} * {32'd0, m_b}; {m_hi, m_lo} = p; end
      MDU_MADD:  begin
        p = {m_hi, m_lo} + 64'(longint'(signed'(m_a)) * longint'(signed'(m_b)));
        {m_hi, m_lo} = p;
      end
      MDU_MADDU: begin p = {m_hi, m_lo} + {32'd0, m_a} * {32'd0, m_b}; {m_hi, m_lo} = p; end
      MDU_DIV: begin
        if (m_b != 32'd0) begin
          if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'd0;
          end else begin
            sa = m_a;
            sb = m_b;
            m_lo = sa / sb;
            m_hi = sa % sb;
          end
        end
      end
      MDU_DIVU: begin
        if (m_b != 32'd0) begin
          m_lo = m_a / m_b;
          m_hi = m_a % m_b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic start, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic req);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) model_commit();
    end else if (!req) begin
      if (start && op_starts(op)) begin
        m_left = op_latency(op);
        m_op   = op;
        m_a    = a;
        m_b    = b;
      end else if (op == MDU_MTHI) begin
        m_hi = a;
      end else if (op == MDU_MTLO) begin
        m_lo = a;
      end
    end
  endtask

  task automatic model_reset();
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_left = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, settle past the compare point.
  task automatic step(input logic start, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic req);
    bus.Start = start;
    bus.MDUop = op;
    bus.A     = a;
    bus.B     = b;
    bus.Req   = req;
    @(posedge clk);
    model_edge(start, op, a, b, req);
    @(negedge clk);
    #1;
  endtask

  task automatic run_busy(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_n);
    int n;
    n = 0;
    step(1'b1, op, a, b, 1'b0);
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step(1'b0, MDU_NULL, 32'd0, 32'd0, 1'b0);
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] exp_out;
      exp_out = (bus.MDUop == MDU_MFHI) ? m_hi :
                (bus.MDUop == MDU_MFLO) ? m_lo : 32'd0;
      check("busy",   {31'd0, bus.Busy}, {31'd0, (m_left > 0)});
      check("hi",     bus.HI, m_hi);
      check("lo",     bus.LO, m_lo);
      check("mduout", bus.MDUout, exp_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.Start = 1'b0;
    bus.MDUop = MDU_NULL;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.Req   = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    cmp_en = 1'b1;
    step(1'b0, MDU_NULL, 32'd0, 32'd0, 1'b0);

    run_busy("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd2, 5);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);
    run_busy("multu", MDU_MULTU, 32'hFFFF_FFFD, 32'd2, 5);
    check("multu_hi", bus.HI, 32'h0000_0001);
    check("multu_lo", bus.LO, 32'hFFFF_FFFA);

    run_busy("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);
    run_busy("divu", MDU_DIVU, 32'd7, 32'd2, 10);
    check("divu_lo", bus.LO, 32'd3);
    check("divu_hi", bus.HI, 32'd1);

    step(1'b0, MDU_MTHI, 32'h11, 32'd0, 1'b0);
    step(1'b0, MDU_MTLO, 32'h22, 32'd0, 1'b0);
    run_busy("div0", MDU_DIV, 32'd1234, 32'd0, 10);
    check("div0_hi", bus.HI, 32'h11);
    check("div0_lo", bus.LO, 32'h22);

    step(1'b0, MDU_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    check("mthi_req_hi", bus.HI, 32'h11);
    step(1'b0, MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", bus.HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, bus.Busy}, 32'd0);
    step(1'b0, MDU_MFLO, 32'd0, 32'd0, 1'b0);
    check("mflo_out", bus.MDUout, 32'h22);

    run_busy("ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("ovf_lo", bus.LO, 32'h8000_0000);
    check("ovf_hi", bus.HI, 32'd0);

    step(1'b1, MDU_MULT, 32'd3, 32'd4, 1'b1);
    check("req_start_busy", {31'd0, bus.Busy}, 32'd0);
    check("req_start_lo", bus.LO, 32'h8000_0000);

    // In-flight div with Req, a stray Start and an mthi arriving while Busy.
    step(1'b1, MDU_DIV, 32'd100, 32'd7, 1'b0);
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      case (n)
        2:       step(1'b1, MDU_MULT, 32'd5, 32'd5, 1'b0);
        3:       step(1'b0, MDU_NULL, 32'd0, 32'd0, 1'b1);
        4:       step(1'b0, MDU_MTHI, 32'hDEAD, 32'd0, 1'b0);
        5:       step(1'b1, MDU_DIVU, 32'd9, 32'd2, 1'b1);
        default: step(1'b0, MDU_NULL, 32'd0, 32'd0, 1'b0);
      endcase
    end
    check("req_run_cycles", 32'(n), 32'd10);
    check("req_run_lo", bus.LO, 32'd14);
    check("req_run_hi", bus.HI, 32'd2);

    step(1'b0, MDU_MTHI, 32'd0, 32'd0, 1'b0);
    step(1'b0, MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    run_busy("maddu", MDU_MADDU, 32'd1, 32'd1, 5);
    check("maddu_hi", bus.HI, 32'd1);
    check("maddu_lo", bus.LO, 32'd0);
`else
    run_busy("maddu", MDU_MADDU, 32'd1, 32'd1, 0);
    check("maddu_hi", bus.HI, 32'd0);
    check("maddu_lo", bus.LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 11)),
           pick_val(), pick_val(), ($urandom_range(0, 5) == 0));
    end
    while (bus.Busy === 1'b1 && n < 80) begin
      n++;
      step(1'b0, MDU_NULL, 32'd0, 32'd0, 1'b0);
    end

    // Asynchronous reset in the middle of a divide.
    step(1'b0, MDU_MTHI, 32'hAAAA, 32'd0, 1'b0);
    step(1'b0, MDU_MTLO, 32'h5555, 32'd0, 1'b0);
    step(1'b1, MDU_DIV, 32'h1000, 32'd3, 1'b0);
    repeat (3) step(1'b0, MDU_NULL, 32'd0, 32'd0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_busy", {31'd0, bus.Busy}, 32'd0);
    check("async_hi", bus.HI, 32'd0);
    check("async_lo", bus.LO, 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    step(1'b0, MDU_MFHI, 32'd0, 32'd0, 1'b0);
    check("post_rst_mfhi", bus.MDUout, 32'd0);
    run_busy("post_rst_mult", MDU_MULT, 32'd6, 32'd7, 5);
    check("post_rst_lo", bus.LO, 32'd42);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes MDUop/Start/Md/Mf/Mt from the instruction decoder; owns the architectural HI/LO registers.
- Models multi-cycle latency with a Busy counter so the hazard unit can stall dependent MDU instructions in D.
- Supplies the mfhi/mflo result to the E-stage forwarding mux (FwSel_mduout).

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15
DIV_CYCLES, 10, Busy cycles for div/divu; legal range 1..15

Ports:
clk  in  1  pipeline clock; all state on rising edge
reset  in  1  asynchronous, active-low; clears all state immediately
Start  in  1  E-stage instruction is mult/multu/div/divu (madd/maddu when enabled)
MDUop  in  4  operation code from mdu_pkg
A  in  32  forwarded rs value
B  in  32  forwarded rt value
Req  in  1  exception/interrupt taken this cycle; suppresses E-stage side effects
Busy  out  1  registered; high while an operation is in flight
MDUout  out  32  HI for mfhi, LO for mflo, else 0 (combinational)
HI  out  32  architectural HI (debug/visibility)
LO  out  32  architectural LO (debug/visibility)

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, Busy=0, counter=0, pending result cleared. Release is synchronous to the next clk edge.
- Start sampled in cycle T with Req=0 and Busy=0:
  - Operands latch and the result is computed into pending regs.
  - Busy is high in cycles T+1..T+N, where N=MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at the edge ending T+N; Busy=0 and the new HI/LO are visible from T+N+1.
- FSM:
  - IDLE -> RUN on an accepted Start; counter loads N-1.
  - RUN decrements the counter; at counter==0 it commits HI/LO and returns to IDLE.
- Start while Busy=1: ignored (protocol violation; the hazard unit guarantees stall). The bench checks no state corruption.
- Req=1: Start, mthi and mtlo in the same cycle are discarded. Req during RUN does not abort; the in-flight op belongs to an older, committed instruction and completes normally.
- mult: signed 32x32 -> {HI,LO} 64-bit. multu: unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign. divu: unsigned.
- B==0 for div/divu: HI/LO unchanged at commit; Busy timing is unchanged.
- 0x80000000 / -1 (div): LO=0x80000000, HI=0.
- mthi/mtlo (Req=0, Busy=0): HI or LO takes A at the next edge; Busy stays 0.
- mthi/mtlo while Busy: ignored (stall guarantees this never occurs).
- MDUout reflects the committed HI/LO only; the pending result is never forwarded. mfhi/mflo while Busy returns the old value, and the hazard unit must stall.
- MDUop null or unknown: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MDUop codes madd (4'd9) and maddu (4'd10) are accepted with Start.
  - {HI,LO} += signed/unsigned A*B, modulo 2^64, with MULT_CYCLES latency.
  - The accumulate uses HI/LO at commit time.
- Undefined: codes 9/10 behave as null; Start with them is ignored.

Decomposition:
- Shared package mdu_pkg holds the MDUop encodings:
  - null=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, madd=9, maddu=10.
  - The decoder uses the same package.
- Sub-module mdu_arith: combinational 64-bit result generator (mult/multu/div/divu/madd), keeping mdu_unit to FSM, counter and HI/LO.

Test Plan:
- Reset check: assert reset mid-RUN of div -> Busy, HI, LO read 0 immediately; after release, mfhi -> MDUout=0.
- mult A=0xFFFFFFFD, B=2 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1. div by B=0 after mthi 0x11/mtlo 0x22 -> HI=0x11, LO=0x22 after 10 cycles.
- mthi A=0x12345678 with Req=1 -> HI unchanged. Same with Req=0 -> HI=0x12345678 next cycle, Busy stays 0. mflo -> MDUout=LO.
- Start mult with Req=1 -> Busy stays 0, HI/LO unchanged. Req pulse during an accepted div's RUN -> result still committed at cycle 10.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and Busy=0.
